timer_test_bench: RTL and testbench

8-bit APB-programmable up/down timer: one reload register, one control register, one status register and a read-only counter, all behind an APB slave with a configurable number of wait states.
Sits on the peripheral bus as a general-purpose tick and timeout source.
The CPU bus model drives stimulus on the APB side; verification probes the internal counter CNT directly.

---
 rtl/timer_test_bench_if.sv | 22 ++
 rtl/timer_test_bench.sv | 185 ++++++++++++++++++
 tb/tb_timer_test_bench.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_test_bench_if.sv
// APB bus bundle for the 8-bit up/down timer.
// The master modport is the CPU bus model; the slave modport is the timer.
interface timer_test_bench_if;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/timer_test_bench.sv
// 8-bit APB-programmable up/down timer.
// Registers: TDR (reload), TCR (control), TSR (OVF/UDF flags), TCNT (read-only counter view).
// WAIT_CYCLES sets how many pready-low cycles each access phase holds before completing.
// Optional macro TIMER_IRQ_EN adds tmr_ovf_irq / tmr_udf_irq, registered copies of the flags.
module timer_test_bench #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic               pclk,
    input  logic               rst,
    timer_test_bench_if.slave  bus
`ifdef TIMER_IRQ_EN
    ,
    output logic               tmr_ovf_irq,
    output logic               tmr_udf_irq
`endif
);

    localparam int WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES);

    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TCNT = 8'h03;

    // Bus-side state
    logic [WW-1:0] waitCnt_q, waitCnt_d;
    logic          accessPhase;
    logic          readyInt;
    logic          xferDone;
    logic          wrEn;
    logic          rdEn;
    logic          addrMapped;

    // Timer state
    logic [7:0] tdr_q, tdr_d;
    logic [7:0] tcr_q, tcr_d;
    logic [1:0] tsr_q, tsr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] presc_q, presc_d;

    // Decoded control fields and events
    logic       ctlLoad;
    logic       ctlDir;
    logic       ctlEn;
    logic [1:0] ctlCks;
    logic [3:0] prescLast;
    logic       running;
    logic       tick;
    logic       ovfSet;
    logic       udfSet;

    assign accessPhase = bus.psel & bus.penable;
    assign readyInt    = (waitCnt_q == WAIT_LAST);
    assign xferDone    = accessPhase & readyInt;
    assign wrEn        = xferDone & bus.pwrite;
    assign rdEn        = xferDone & ~bus.pwrite;
    assign addrMapped  = (bus.paddr <= ADDR_TCNT);

    assign bus.pready  = readyInt;
    assign bus.pslverr = xferDone & ~addrMapped;

    assign ctlLoad = tcr_q[7];
    assign ctlDir  = tcr_q[5];
    assign ctlEn   = tcr_q[4];
    assign ctlCks  = tcr_q[1:0];

    // Count wait states while an access phase is stalled; idle or completed phases restart at zero
    always_comb begin
        waitCnt_d = '0;
        if (accessPhase && !readyInt) begin
            waitCnt_d = waitCnt_q + 1'b1;
        end
    end

    // Wait-state counter register
    always_ff @(posedge pclk) begin
        if (rst) begin
            waitCnt_q <= '0;
        end else begin
            waitCnt_q <= waitCnt_d;
        end
    end

    // Read mux: data only during the completing read cycle, zero otherwise and for unmapped addresses
    always_comb begin
        bus.prdata = 8'h00;
        if (rdEn) begin
            case (bus.paddr)
                ADDR_TDR:  bus.prdata = tdr_q;
                ADDR_TCR:  bus.prdata = tcr_q;
                ADDR_TSR:  bus.prdata = {6'b000000, tsr_q};
                ADDR_TCNT: bus.prdata = cnt_q;
                default:   bus.prdata = 8'h00;
            endcase
        end
    end

    // Last prescaler value before a tick for each clock-select: divide by 2, 4, 8 or 16
    always_comb begin
        prescLast = 4'd1;
        case (ctlCks)
            2'b00:   prescLast = 4'd1;
            2'b01:   prescLast = 4'd3;
            2'b10:   prescLast = 4'd7;
            default: prescLast = 4'd15;
        endcase
    end

    assign running = ctlEn & ~ctlLoad;
    assign tick    = running & (presc_q == prescLast);

    // Prescaler advances only while running; held at zero otherwise so a restart takes a full period
    always_comb begin
        presc_d = 4'd0;
        if (running && !tick) begin
            presc_d = presc_q + 4'd1;
        end
    end

    // Counter: LOAD copies the current TDR every cycle; otherwise a tick steps up or down modulo 256
    always_comb begin
        cnt_d  = cnt_q;
        ovfSet = 1'b0;
        udfSet = 1'b0;
        if (ctlLoad) begin
            cnt_d = tdr_q;
        end else if (tick) begin
            if (ctlDir) begin
                cnt_d  = cnt_q - 8'd1;
                udfSet = (cnt_q == 8'h00);
            end else begin
                cnt_d  = cnt_q + 8'd1;
                ovfSet = (cnt_q == 8'hFF);
            end
        end
    end

    // Register writes; TSR clears flags written as 0 but a same-cycle event still sets them
    always_comb begin
        tdr_d = tdr_q;
        tcr_d = tcr_q;
        tsr_d = tsr_q;
        if (wrEn) begin
            case (bus.paddr)
                ADDR_TDR: tdr_d = bus.pwdata;
                ADDR_TCR: tcr_d = bus.pwdata;
                ADDR_TSR: tsr_d = tsr_q & bus.pwdata[1:0];
                default:  ;
            endcase
        end
        tsr_d = tsr_d | {udfSet, ovfSet};
    end

    // Timer register bank
    always_ff @(posedge pclk) begin
        if (rst) begin
            tdr_q   <= 8'h00;
            tcr_q   <= 8'h00;
            tsr_q   <= 2'b00;
            cnt_q   <= 8'h00;
            presc_q <= 4'd0;
        end else begin
            tdr_q   <= tdr_d;
            tcr_q   <= tcr_d;
            tsr_q   <= tsr_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
        end
    end

`ifdef TIMER_IRQ_EN
    // Interrupt lines follow the status flags one cycle later and stay high until software clears them
    always_ff @(posedge pclk) begin
        if (rst) begin
            tmr_ovf_irq <= 1'b0;
            tmr_udf_irq <= 1'b0;
        end else begin
            tmr_ovf_irq <= tsr_q[0];
            tmr_udf_irq <= tsr_q[1];
        end
    end
`endif

endmodule

// File: tb/tb_timer_test_bench.sv
// Self-checking bench for timer_test_bench: directed scenarios followed by random register traffic,
// all compared against a behavioural model that counts enabled cycles and derives ticks arithmetically.
// Define TIMER_IRQ_EN to also check the interrupt outputs.
module tb_timer_test_bench;

    parameter int WAIT_CYCLES = 0;

    logic pclk = 1'b0;
    logic rst;

    timer_test_bench_if bus ();

`ifdef TIMER_IRQ_EN
    logic tmrOvfIrq;
    logic tmrUdfIrq;
`endif

    timer_test_bench #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
        .pclk        (pclk),
        .rst         (rst),
        .bus         (bus)
`ifdef TIMER_IRQ_EN
        ,
        .tmr_ovf_irq (tmrOvfIrq),
        .tmr_udf_irq (tmrUdfIrq)
`endif
    );

    always #5 pclk = ~pclk;

    int errorCount = 0;
    int checkCount = 0;

    // Behavioural model state
    logic [7:0] mTdr, mTcr, mCnt;
    logic       mOvf, mUdf, mIrqOvf, mIrqUdf;
    int         mRun;

    // Compare one observed value with its expected value
    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    function automatic void modelReset();
        mTdr = 8'h00; mTcr = 8'h00; mCnt = 8'h00;
        mOvf = 1'b0; mUdf = 1'b0; mIrqOvf = 1'b0; mIrqUdf = 1'b0;
        mRun = 0;
    endfunction

    // One clock edge of the timer as described by its rules; wr/a/d describe a write committing here
    function automatic void modelStep(input bit wr, input logic [7:0] a, input logic [7:0] d);
        int         n;
        logic [7:0] nextCnt;
        logic       setOvf, setUdf, keepOvf, keepUdf;
        n       = 2 << mTcr[1:0];
        nextCnt = mCnt;
        setOvf  = 1'b0;
        setUdf  = 1'b0;
        mIrqOvf = mOvf;
        mIrqUdf = mUdf;
        if (mTcr[7]) begin
            nextCnt = mTdr;
            mRun    = 0;
        end else if (mTcr[4]) begin
            mRun++;
            if (mRun % n == 0) begin
                if (mTcr[5]) begin
                    nextCnt = 8'((int'(mCnt) + 255) % 256);
                    setUdf  = (mCnt == 8'h00);
                end else begin
                    nextCnt = 8'((int'(mCnt) + 1) % 256);
                    setOvf  = (mCnt == 8'hFF);
                end
            end
        end else begin
            mRun = 0;
        end
        keepOvf = mOvf;
        keepUdf = mUdf;
        if (wr) begin
            case (a)
                8'h00: mTdr = d;
                8'h01: mTcr = d;
                8'h02: begin keepOvf = mOvf & d[0]; keepUdf = mUdf & d[1]; end
                default: ;
            endcase
        end
        mOvf = keepOvf | setOvf;
        mUdf = keepUdf | setUdf;
        mCnt = nextCnt;
    endfunction

    function automatic logic [7:0] modelRead(input logic [7:0] a);
        case (a)
            8'h00:   return mTdr;
            8'h01:   return mTcr;
            8'h02:   return {6'b000000, mUdf, mOvf};
            8'h03:   return mCnt;
            default: return 8'h00;
        endcase
    endfunction

    // Advance one clock, keep the model in lockstep, and settle just after the edge
    task automatic step(input bit wr, input logic [7:0] a, input logic [7:0] d);
        @(posedge pclk);
        if (rst) modelReset();
        else     modelStep(wr, a, d);
        #1;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00);
    endtask

    // Drive one complete APB transfer; the wait-state count and completion are checked here
    task automatic applyStimulus(input bit wr, input logic [7:0] a, input logic [7:0] d,
                                 output logic [7:0] rd, output logic err);
        int waits;
        bit done;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = a;
        bus.pwdata  = d;
        step(1'b0, 8'h00, 8'h00);
        bus.penable = 1'b1;
        waits = 0;
        done  = 1'b0;
        rd    = 8'h00;
        err   = 1'b0;
        for (int i = 0; i < WAIT_CYCLES + 4 && !done; i++) begin
            #2;
            if (bus.pready) begin
                rd   = bus.prdata;
                err  = bus.pslverr;
                done = 1'b1;
                step(wr, a, d);
            end else begin
                waits++;
                step(1'b0, 8'h00, 8'h00);
            end
        end
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        checkOutput("readyTimeout", 8'(done), 8'd1);
        checkOutput("waitStates", 8'(waits), 8'(WAIT_CYCLES));
    endtask

    task automatic writeReg(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] rd;
        logic       err;
        applyStimulus(1'b1, a, d, rd, err);
        checkOutput("writeErr", 8'(err), 8'(a > 8'h03));
    endtask

    task automatic readReg(input string tag, input logic [7:0] a, output logic [7:0] rd);
        logic       err;
        logic [7:0] exp;
        exp = modelRead(a);
        applyStimulus(1'b0, a, 8'h00, rd, err);
        checkOutput({tag, "Data"}, rd, exp);
        checkOutput({tag, "Err"}, 8'(err), 8'(a > 8'h03));
    endtask

    task automatic checkCnt(input string tag);
        checkOutput(tag, dut.cnt_q, mCnt);
`ifdef TIMER_IRQ_EN
        checkOutput({tag, "IrqOvf"}, 8'(tmrOvfIrq), 8'(mIrqOvf));
        checkOutput({tag, "IrqUdf"}, 8'(tmrUdfIrq), 8'(mIrqUdf));
`endif
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] a;
        logic [7:0] d;

        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = 8'h00; bus.pwdata = 8'h00;
        rst = 1'b1;
        modelReset();
        step(1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h00, 8'h00);
        rst = 1'b0;

        // Reset state
        checkOutput("rstPready", 8'(bus.pready), 8'(WAIT_CYCLES == 0));
        checkOutput("rstPslverr", 8'(bus.pslverr), 8'h00);
        checkOutput("rstPrdata", bus.prdata, 8'h00);
        checkOutput("rstCnt", dut.cnt_q, 8'h00);
        readReg("rstTdr", 8'h00, rd);
        checkOutput("rstTdrConst", rd, 8'h00);
        readReg("rstTcr", 8'h01, rd);
        readReg("rstTsr", 8'h02, rd);
        readReg("rstTcnt", 8'h03, rd);
        readReg("unmapped", 8'h10, rd);

        // Down count at /2, stop/freeze, resume until a full wrap
        writeReg(8'h01, 8'h30);
        readReg("tcrRun", 8'h01, rd);
        checkOutput("tcrRunConst", rd, 8'h30);
        runCycles(200);
        writeReg(8'h01, 8'h00);
        readReg("tcrStop", 8'h01, rd);
        checkCnt("stoppedCnt");
        a = dut.cnt_q;
        runCycles(200);
        checkOutput("frozenCnt", dut.cnt_q, a);
        writeReg(8'h01, 8'h30);
        readReg("tcrResume", 8'h01, rd);
        runCycles(301);
        checkCnt("wrapCnt");
        readReg("udfFlag", 8'h02, rd);
        checkOutput("udfFlagConst", rd & 8'h02, 8'h02);

        // Load then first tick exactly 16 cycles after enabling at /16
        writeReg(8'h01, 8'h00);
        writeReg(8'h02, 8'h00);
        writeReg(8'h00, 8'h05);
        writeReg(8'h01, 8'h80);
        writeReg(8'h01, 8'h13);
        checkOutput("loadCnt", dut.cnt_q, 8'h05);
        runCycles(15);
        checkOutput("loadHold", dut.cnt_q, 8'h05);
        runCycles(1);
        checkOutput("firstTick", dut.cnt_q, 8'h06);
        checkCnt("firstTickModel");

        // Overflow from 0xFE at /2 and flag clearing semantics
        writeReg(8'h01, 8'h00);
        writeReg(8'h02, 8'h00);
        writeReg(8'h00, 8'hFE);
        writeReg(8'h01, 8'h80);
        writeReg(8'h01, 8'h10);
        checkOutput("ovfStart", dut.cnt_q, 8'hFE);
        runCycles(2);
        checkOutput("ovfStep1", dut.cnt_q, 8'hFF);
        runCycles(2);
        checkOutput("ovfStep2", dut.cnt_q, 8'h00);
        readReg("ovfTsr", 8'h02, rd);
        checkOutput("ovfTsrConst", rd, 8'h01);
        writeReg(8'h01, 8'h00);
        writeReg(8'h02, 8'hFE);
        readReg("ovfCleared", 8'h02, rd);
        checkOutput("ovfClearedConst", rd, 8'h00);
        writeReg(8'h02, 8'hFF);
        readReg("tsrKeep", 8'h02, rd);

        // Writes to TCNT are ignored without error
        a = dut.cnt_q;
        writeReg(8'h03, 8'hAA);
        checkOutput("tcntWriteIgnored", dut.cnt_q, a);
        checkCnt("tcntWriteModel");

        // Reset during an access phase aborts the write
        writeReg(8'h00, 8'h11);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 8'h00; bus.pwdata = 8'h77;
        step(1'b0, 8'h00, 8'h00);
        bus.penable = 1'b1;
        rst = 1'b1;
        step(1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        bus.psel = 1'b0; bus.penable = 1'b0;
        step(1'b0, 8'h00, 8'h00);
        readReg("abortTdr", 8'h00, rd);
        checkOutput("abortTdrConst", rd, 8'h00);

        // Random register traffic against the model
        for (int it = 0; it < 60; it++) begin
            d = 8'($urandom);
            case ($urandom_range(0, 5))
                0: writeReg(8'h00, d);
                1: begin
                    writeReg(8'h01, 8'h00);
                    writeReg(8'h01, d);
                end
                2: runCycles(int'($urandom_range(1, 40)));
                3: begin
                    a = ($urandom_range(0, 4) == 4) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
                    readReg("randRead", a, rd);
                end
                4: writeReg(8'h02, d);
                default: writeReg(8'h03, d);
            endcase
            checkCnt("randCnt");
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
